multicycle_control_unit: RTL

//  Multicycle MIPS main control FSM: replaces the single-cycle opcode decoder for the shared-memory datapath.

---
 rtl/mips_ctrl_pkg.sv | 39 +++
 rtl/multicycle_control_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux/ALU selector values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RCOMP  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable, with a memory-ready handshake.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int EN_ADDI  = 1,
    parameter int EN_BNE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                branch_ne,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic                memtoreg,
    output logic                regdest,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          pcsource,
    output logic                illegal_op
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [1:0] aluop_c;

    logic is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, is_addi;

    assign is_rtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign is_lw    = (opcode == OPCODE_W'(OP_LW));
    assign is_sw    = (opcode == OPCODE_W'(OP_SW));
    assign is_beq   = (opcode == OPCODE_W'(OP_BEQ));
    assign is_bne   = (opcode == OPCODE_W'(OP_BNE));
    assign is_j     = (opcode == OPCODE_W'(OP_J));
    assign is_addi  = (opcode == OPCODE_W'(OP_ADDI));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_lw || is_sw)                 state_nxt = S_MEMADR;
                else if (is_rtype)                  state_nxt = S_EXEC;
                else if (is_beq)                    state_nxt = S_BRANCH;
                else if (is_bne && (EN_BNE != 0))   state_nxt = S_BRANCH;
                else if (is_j)                      state_nxt = S_JUMP;
                else if (is_addi && (EN_ADDI != 0)) state_nxt = S_ADDIEX;
                else                                state_nxt = S_FETCH;
            end
            // IR holds the opcode, so lw/sw can still be told apart here
            S_MEMADR: begin
                if (is_lw)      state_nxt = S_MEMRD;
                else if (is_sw) state_nxt = S_MEMWR;
                else            state_nxt = S_FETCH;
            end
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_RCOMP;
            S_RCOMP:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // All outputs are held low while reset is asserted, regardless of state
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        branch_ne   = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_B;
        aluop_c     = ALUOP_ADD;
        pcsource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = ALUSRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb    = ALUSRCB_IMMSH2;
                    illegal_op = !(is_lw || is_sw || is_rtype || is_beq || is_j
                                   || (is_bne && (EN_BNE != 0))
                                   || (is_addi && (EN_ADDI != 0)));
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = ALUSRCB_IMM;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop_c = ALUOP_FUNCT;
                end
                S_RCOMP: begin
                    regwrite = 1'b1;
                    regdest  = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    aluop_c     = ALUOP_SUB;
                    pcwritecond = 1'b1;
                    pcsource    = PCSRC_ALUOUT;
                    branch_ne   = is_bne;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_JUMP;
                end
                S_ADDIWB: regwrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign aluop = ALUOP_W'(aluop_c);

endmodule
